// File: rtl/ksa_pkg.sv
// Shared types for the RC4 key-scheduling swap engine: FSM state encoding and
// the supported memory read latency limit.
package ksa_pkg;

  localparam int unsigned MAX_RD_LAT = 4;

  // Explicit encoding so waveform viewers show stable state values.
  typedef enum logic [3:0] {
    StIdle  = 4'h0,
    StFill  = 4'h1,
    StRdI   = 4'h2,
    StWaitI = 4'h3,
    StGetI  = 4'h4,
    StRdJ   = 4'h5,
    StWaitJ = 4'h6,
    StGetJ  = 4'h7,
    StWrI   = 4'h8,
    StWrJ   = 4'h9,
    StInc   = 4'hA,
    StDone  = 4'hB
  } ksa_state_e;

endpackage

// File: rtl/key_byte_sel.sv
// Selects byte i_idx of a packed key; byte 0 is the most significant byte.
module key_byte_sel #(
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [8*KEY_BYTES-1:0] i_key,
  input  logic [IDX_W-1:0]       i_idx,
  output logic [7:0]             o_byte
);

  always_comb begin
    o_byte = 8'h00;
    for (int unsigned n = 0; n < KEY_BYTES; n++) begin
      if (i_idx == IDX_W'(n)) o_byte = i_key[8*(KEY_BYTES-1-n) +: 8];
    end
  end

endmodule

// File: rtl/ksa_swap_engine.sv
// RC4 key-scheduling swap engine driving one single-port S-memory.
// Optional identity-fill phase enabled by defining KSA_INIT_FILL_EN.
module ksa_swap_engine
  import ksa_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_flag,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [DATA_W-1:0]      data_out,
  output logic [ADDR_W-1:0]      address,
  output logic [DATA_W-1:0]      data_in,
  output logic                   wren,
  output logic                   done_flag
);

  localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int unsigned WAIT_W = $clog2(MAX_RD_LAT + 1);

  ksa_state_e        r_state;
  logic [ADDR_W-1:0] r_i;
  logic [DATA_W-1:0] r_j;
  logic [KIDX_W-1:0] r_k;
  logic [DATA_W-1:0] r_si;
  logic [WAIT_W-1:0] r_wait;

  logic [7:0]        w_key_byte;
  logic [DATA_W-1:0] w_key_ext;
  logic [DATA_W-1:0] w_j_next;
  logic [ADDR_W-1:0] w_i_inc;
  logic              w_i_last;
  logic              w_wait_end;

  key_byte_sel #(
    .KEY_BYTES(KEY_BYTES),
    .IDX_W    (KIDX_W)
  ) u_key_byte_sel (
    .i_key (secret_key),
    .i_idx (r_k),
    .o_byte(w_key_byte)
  );

  assign w_key_ext  = DATA_W'(w_key_byte);
  assign w_j_next   = r_j + data_out + w_key_ext;
  assign w_i_inc    = r_i + 1'b1;
  assign w_i_last   = (r_i == {ADDR_W{1'b1}});
  assign w_wait_end = (r_wait == WAIT_W'(RD_LAT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_i       <= '0;
      r_j       <= '0;
      r_k       <= '0;
      r_si      <= '0;
      r_wait    <= '0;
      address   <= '0;
      data_in   <= '0;
      wren      <= 1'b0;
      done_flag <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_i       <= '0;
          r_j       <= '0;
          r_k       <= '0;
          wren      <= 1'b0;
          done_flag <= 1'b0;
          if (start_flag) begin
            address <= '0;
            data_in <= '0;
`ifdef KSA_INIT_FILL_EN
            wren    <= 1'b1;
            r_state <= StFill;
`else
            r_state <= StRdI;
`endif
          end
        end
`ifdef KSA_INIT_FILL_EN
        // One identity write per cycle; r_i doubles as the fill address.
        StFill: begin
          if (w_i_last) begin
            r_i     <= '0;
            address <= '0;
            wren    <= 1'b0;
            r_state <= StRdI;
          end else begin
            r_i     <= w_i_inc;
            address <= w_i_inc;
            data_in <= DATA_W'(w_i_inc);
          end
        end
`endif
        StRdI: begin
          r_wait  <= WAIT_W'(1);
          r_state <= StWaitI;
        end
        StWaitI: begin
          r_wait <= r_wait + 1'b1;
          if (w_wait_end) r_state <= StGetI;
        end
        StGetI: begin
          r_si    <= data_out;
          r_j     <= w_j_next;
          address <= ADDR_W'(w_j_next);
          r_state <= StRdJ;
        end
        StRdJ: begin
          r_wait  <= WAIT_W'(1);
          r_state <= StWaitJ;
        end
        StWaitJ: begin
          r_wait <= r_wait + 1'b1;
          if (w_wait_end) r_state <= StGetJ;
        end
        // S[j] goes straight to the write-data register; no separate sj latch.
        StGetJ: begin
          address <= r_i;
          data_in <= data_out;
          wren    <= 1'b1;
          r_state <= StWrI;
        end
        StWrI: begin
          address <= ADDR_W'(r_j);
          data_in <= r_si;
          wren    <= 1'b1;
          r_state <= StWrJ;
        end
        StWrJ: begin
          wren    <= 1'b0;
          r_state <= StInc;
        end
        StInc: begin
          r_i <= w_i_inc;
          r_k <= (r_k == KIDX_W'(KEY_BYTES - 1)) ? '0 : r_k + 1'b1;
          if (w_i_last) begin
            done_flag <= 1'b1;
            r_state   <= StDone;
          end else begin
            address <= w_i_inc;
            r_state <= StRdI;
          end
        end
        StDone: begin
          wren <= 1'b0;
          if (!start_flag) begin
            done_flag <= 1'b0;
            r_state   <= StIdle;
          end
        end
        default: begin
          wren    <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ksa_swap_engine.sv
// Bench for ksa_swap_engine: three instances (default, RD_LAT=3, KEY_BYTES=5), each
// with its own S-memory model, checked against a plain-arithmetic RC4 KSA model.
module tb_ksa_swap_engine;

`ifdef KSA_INIT_FILL_EN
  localparam int FillCyc = 256;
`else
  localparam int FillCyc = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset   = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic [23:0] key_a   = '0, key_b = '0;
  logic [39:0] key_c   = '0;
  logic [7:0]  q_a, q_b, q_c, din_a, din_b, din_c, addr_a, addr_b, addr_c;
  logic        wren_a, wren_b, wren_c, done_a, done_b, done_c;

  ksa_swap_engine u_dut_a (
    .clk(clk), .reset(reset), .start_flag(start_a), .secret_key(key_a), .data_out(q_a),
    .address(addr_a), .data_in(din_a), .wren(wren_a), .done_flag(done_a)
  );

  ksa_swap_engine #(.RD_LAT(3)) u_dut_b (
    .clk(clk), .reset(reset), .start_flag(start_b), .secret_key(key_b), .data_out(q_b),
    .address(addr_b), .data_in(din_b), .wren(wren_b), .done_flag(done_b)
  );

  ksa_swap_engine #(.KEY_BYTES(5)) u_dut_c (
    .clk(clk), .reset(reset), .start_flag(start_c), .secret_key(key_c), .data_out(q_c),
    .address(addr_c), .data_in(din_c), .wren(wren_c), .done_flag(done_c)
  );

  // Memory models: q shows the word addressed RD_LAT cycles earlier.
  logic [7:0] img   [256];
  logic [7:0] mem_a [256];
  logic [7:0] mem_b [256];
  logic [7:0] mem_c [256];
  logic       ld_a = 1'b0, ld_b = 1'b0, ld_c = 1'b0;
  logic [7:0] pa, pc;
  logic [7:0] pb [3];
  int         wcnt_a = 0, wcnt_b = 0, wcnt_c = 0;

  always @(posedge clk) begin
    if (ld_a) mem_a <= img;
    else if (wren_a) mem_a[addr_a] <= din_a;
    pa <= mem_a[addr_a];
    if (wren_a) wcnt_a <= wcnt_a + 1;
  end

  always @(posedge clk) begin
    if (ld_b) mem_b <= img;
    else if (wren_b) mem_b[addr_b] <= din_b;
    pb[0] <= mem_b[addr_b];
    pb[1] <= pb[0];
    pb[2] <= pb[1];
    if (wren_b) wcnt_b <= wcnt_b + 1;
  end

  always @(posedge clk) begin
    if (ld_c) mem_c <= img;
    else if (wren_c) mem_c[addr_c] <= din_c;
    pc <= mem_c[addr_c];
    if (wren_c) wcnt_c <= wcnt_c + 1;
  end

  assign q_a = pa;
  assign q_b = pb[2];
  assign q_c = pc;

  int         checks = 0;
  int         errors = 0;
  int         bad_idx = 0;
  int         ref_s [256];
  logic [7:0] snap [9][256];

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  function automatic logic [7:0] get_mem(input int sel, input int idx);
    case (sel)
      0:       return mem_a[idx];
      1:       return mem_b[idx];
      default: return mem_c[idx];
    endcase
  endfunction

  function automatic int count_bad(input int sel);
    int n = 0;
    for (int i = 0; i < 256; i++) begin
      if (get_mem(sel, i) !== 8'(ref_s[i])) begin
        if (n == 0) bad_idx = i;
        n++;
      end
    end
    return n;
  endfunction

  function automatic int count_bad_snap(input int m);
    int n = 0;
    for (int i = 0; i < 256; i++) begin
      if (snap[m][i] !== 8'(ref_s[i])) begin
        if (n == 0) bad_idx = i;
        n++;
      end
    end
    return n;
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0:       start_a = v;
      1:       start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic load_img(input int sel);
    @(negedge clk);
    case (sel)
      0:       ld_a = 1'b1;
      1:       ld_b = 1'b1;
      default: ld_c = 1'b1;
    endcase
    @(negedge clk);
    ld_a = 1'b0;
    ld_b = 1'b0;
    ld_c = 1'b0;
  endtask

  task automatic stop_run(input int sel);
    @(negedge clk);
    set_start(sel, 1'b0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic ref_identity();
    for (int i = 0; i < 256; i++) ref_s[i] = i;
  endtask

  // Starting S of a run: the fill phase overwrites whatever was loaded.
  task automatic ref_from_img();
`ifdef KSA_INIT_FILL_EN
    ref_identity();
`else
    for (int i = 0; i < 256; i++) ref_s[i] = int'(img[i]);
`endif
  endtask

  // Reference KSA over the first niter positions of ref_s, j starting at 0.
  task automatic model_ksa(input logic [39:0] key, input int kb, input int niter);
    int j = 0;
    int t, kbyte;
    for (int i = 0; i < niter; i++) begin
      kbyte = int'((key >> (8 * (kb - 1 - (i % kb)))) & 40'hFF);
      j = (j + ref_s[i] + kbyte) % 256;
      t = ref_s[i];
      ref_s[i] = ref_s[j];
      ref_s[j] = t;
    end
  endtask

  // Runs instance sel to done_flag, counting cycles from the start-sampling edge and
  // snapshotting memory at the first few iteration boundaries.
  task automatic run_to_done(input int sel, input bit pre_started, output int cyc);
    int len, lim, m;
    len = (sel == 1) ? 13 : 9;
    lim = FillCyc + 256 * len + 64;
    if (!pre_started) begin
      @(negedge clk);
      set_start(sel, 1'b1);
    end
    @(posedge clk);
    cyc = 0;
    while (cyc < lim) begin
      @(posedge clk);
      cyc++;
      #1;
      m = cyc - FillCyc;
      if (m >= 0 && m % len == 0 && m / len <= 8)
        for (int i = 0; i < 256; i++) snap[m / len][i] = get_mem(sel, i);
      if (get_done(sel)) break;
    end
    checks++;
    if (get_done(sel) !== 1'b1) begin
      errors++;
      $display("FAIL run_timeout sel=%0d done_flag=%b required 1 within %0d cycles",
               sel, get_done(sel), lim);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (wren_a !== 1'b0) begin
      errors++; $display("FAIL reset_wren got %b want 0", wren_a);
    end
    checks++;
    if (addr_a !== 8'h00) begin
      errors++; $display("FAIL reset_address got %h want 00", addr_a);
    end
    checks++;
    if (din_a !== 8'h00) begin
      errors++; $display("FAIL reset_data_in got %h want 00", din_a);
    end
    checks++;
    if (done_a !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b want 0", done_a);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({wren_a, done_a} !== 2'b00) begin
      errors++; $display("FAIL idle_after_release wren,done got %b want 00", {wren_a, done_a});
    end
  endtask

  task automatic test_first_iters();
    int cyc, w0;
    for (int i = 0; i < 256; i++) begin
`ifdef KSA_INIT_FILL_EN
      img[i] = 8'hFF;
`else
      img[i] = 8'(i);
`endif
    end
    load_img(0);
    key_a = 24'h000249;
    w0 = wcnt_a;
    run_to_done(0, 1'b0, cyc);
    checks++;
    if (cyc !== 2304 + FillCyc) begin
      errors++; $display("FAIL run_cycles got %0d want %0d", cyc, 2304 + FillCyc);
    end
`ifdef KSA_INIT_FILL_EN
    ref_identity();
    checks++;
    if (count_bad_snap(0) != 0) begin
      errors++;
      $display("FAIL fill_image S[%0d] got %h want %h", bad_idx, snap[0][bad_idx], bad_idx[7:0]);
    end
`endif
    checks++;
    if (snap[1][0] !== 8'h00 || snap[1][1] !== 8'h01) begin
      errors++;
      $display("FAIL iter0 S[0],S[1] got %h,%h want 00,01", snap[1][0], snap[1][1]);
    end
    checks++;
    if (snap[2][1] !== 8'h03 || snap[2][3] !== 8'h01) begin
      errors++;
      $display("FAIL iter1 S[1],S[3] got %h,%h want 03,01", snap[2][1], snap[2][3]);
    end
    checks++;
    if (snap[3][2] !== 8'h4E || snap[3][8'h4E] !== 8'h02) begin
      errors++;
      $display("FAIL iter2 S[2],S[4E] got %h,%h want 4e,02", snap[3][2], snap[3][8'h4E]);
    end
    ref_identity();
    model_ksa(40'h000249, 3, 256);
    checks++;
    if (count_bad(0) != 0) begin
      errors++;
      $display("FAIL golden_000249 S[%0d] got %h want %h", bad_idx, get_mem(0, bad_idx),
               8'(ref_s[bad_idx]));
    end
    checks++;
    if (wcnt_a - w0 !== 512 + FillCyc) begin
      errors++; $display("FAIL wren_count got %0d want %0d", wcnt_a - w0, 512 + FillCyc);
    end
  endtask

  task automatic test_done_hold();
    int w0, cyc;
    logic [23:0] k;
    w0 = wcnt_a;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (done_a !== 1'b1) begin
      errors++; $display("FAIL hold_done got %b want 1", done_a);
    end
    checks++;
    if (wcnt_a !== w0) begin
      errors++; $display("FAIL hold_wren pulses got %0d want 0", wcnt_a - w0);
    end
    @(negedge clk);
    start_a = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done_a !== 1'b0) begin
      errors++; $display("FAIL done_drop got %b want 0", done_a);
    end
    k = 24'($urandom);
    key_a = k;
`ifdef KSA_INIT_FILL_EN
    ref_identity();
`endif
    model_ksa({16'h0, k}, 3, 256);
    run_to_done(0, 1'b0, cyc);
    checks++;
    if (count_bad(0) != 0) begin
      errors++;
      $display("FAIL rerun_golden key=%h S[%0d] got %h want %h", k, bad_idx,
               get_mem(0, bad_idx), 8'(ref_s[bad_idx]));
    end
    stop_run(0);
  endtask

  task automatic test_random();
    int cyc, w0;
    logic [23:0] k;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
      load_img(0);
      k = 24'($urandom);
      key_a = k;
      ref_from_img();
      model_ksa({16'h0, k}, 3, 256);
      w0 = wcnt_a;
      run_to_done(0, 1'b0, cyc);
      checks++;
      if (count_bad(0) != 0) begin
        errors++;
        $display("FAIL random_golden run=%0d key=%h S[%0d] got %h want %h", r, k, bad_idx,
                 get_mem(0, bad_idx), 8'(ref_s[bad_idx]));
      end
      checks++;
      if (wcnt_a - w0 !== 512 + FillCyc || cyc !== 2304 + FillCyc) begin
        errors++;
        $display("FAIL random_timing run=%0d writes/cycles got %0d/%0d want %0d/%0d", r,
                 wcnt_a - w0, cyc, 512 + FillCyc, 2304 + FillCyc);
      end
      stop_run(0);
    end
  endtask

  task automatic test_rd_lat3();
    int cyc;
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    load_img(1);
    key_b = 24'h000249;
    run_to_done(1, 1'b0, cyc);
    checks++;
    if (cyc !== 3328 + FillCyc) begin
      errors++; $display("FAIL lat3_cycles got %0d want %0d", cyc, 3328 + FillCyc);
    end
    checks++;
    if (snap[2][1] !== 8'h03 || snap[2][3] !== 8'h01) begin
      errors++;
      $display("FAIL lat3_iter1 S[1],S[3] got %h,%h want 03,01", snap[2][1], snap[2][3]);
    end
    ref_identity();
    model_ksa(40'h000249, 3, 256);
    checks++;
    if (count_bad(1) != 0) begin
      errors++;
      $display("FAIL lat3_golden S[%0d] got %h want %h", bad_idx, get_mem(1, bad_idx),
               8'(ref_s[bad_idx]));
    end
    stop_run(1);
  endtask

  task automatic test_key5();
    int cyc;
    for (int i = 0; i < 256; i++) img[i] = 8'(i);
    load_img(2);
    key_c = 40'h0102030405;
    run_to_done(2, 1'b0, cyc);
    ref_identity();
    model_ksa(40'h0102030405, 5, 6);
    checks++;
    if (count_bad_snap(6) != 0) begin
      errors++;
      $display("FAIL key5_wrap S[%0d] got %h want %h", bad_idx, snap[6][bad_idx],
               8'(ref_s[bad_idx]));
    end
    ref_identity();
    model_ksa(40'h0102030405, 5, 256);
    checks++;
    if (count_bad(2) != 0) begin
      errors++;
      $display("FAIL key5_golden S[%0d] got %h want %h", bad_idx, get_mem(2, bad_idx),
               8'(ref_s[bad_idx]));
    end
    stop_run(2);
  endtask

  task automatic test_reset_mid();
    int m, target, rises, guard, cyc;
    logic prev;
    logic [23:0] k;
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    load_img(0);
    k = 24'($urandom);
    key_a = k;
    m = int'($urandom_range(3, 20));
    target = m + 1 + ((FillCyc > 0) ? 1 : 0);
    @(negedge clk);
    start_a = 1'b1;
    rises = 0;
    prev = 1'b0;
    guard = 0;
    while (rises < target && guard < 20000) begin
      @(negedge clk);
      guard++;
      if (wren_a && !prev) rises++;
      prev = wren_a;
    end
    checks++;
    if (rises !== target) begin
      errors++; $display("FAIL reset_mid_reach wr_i entries got %0d want %0d", rises, target);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({wren_a, done_a, addr_a, din_a} !== 18'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs wren=%b done=%b addr=%h din=%h want 0,0,00,00",
               wren_a, done_a, addr_a, din_a);
    end
    ref_from_img();
    model_ksa({16'h0, k}, 3, m);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (count_bad(0) != 0) begin
      errors++;
      $display("FAIL reset_partial iter=%0d S[%0d] got %h want %h", m, bad_idx,
               get_mem(0, bad_idx), 8'(ref_s[bad_idx]));
    end
`ifdef KSA_INIT_FILL_EN
    ref_identity();
`endif
    model_ksa({16'h0, k}, 3, 256);
    @(negedge clk);
    reset = 1'b1;
    run_to_done(0, 1'b1, cyc);
    checks++;
    if (cyc !== 2304 + FillCyc) begin
      errors++; $display("FAIL restart_cycles got %0d want %0d", cyc, 2304 + FillCyc);
    end
    checks++;
    if (count_bad(0) != 0) begin
      errors++;
      $display("FAIL restart_golden S[%0d] got %h want %h", bad_idx, get_mem(0, bad_idx),
               8'(ref_s[bad_idx]));
    end
    stop_run(0);
  endtask

  initial begin
    test_reset();
    test_first_iters();
    test_done_hold();
    test_random();
    test_rd_lat3();
    test_key5();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
